// File: rtl/bank_group_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bank_group_sequencer
// Brief    : Command-side driver for one DDR bank group. Tracks open rows,
//            sequences BL-beat bursts and serialises read beats.
// Revision : 1.0 - initial release
// ============================================================================
module bank_group_sequencer #(
    parameter int BAWIDTH      = 2,
    parameter int ADDRWIDTH    = 17,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int BL           = 8,
    localparam int BANKSPERGROUP = 2**BAWIDTH
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         cmd_valid,
    output logic                                         cmd_ready,
    input  logic [1:0]                                   cmd_op,
    input  logic [BAWIDTH-1:0]                           cmd_ba,
    input  logic [ADDRWIDTH-1:0]                         cmd_addr,
    input  logic [DEVICE_WIDTH-1:0]                      wr_data,
    output logic                                         wr_req,
    output logic [DEVICE_WIDTH-1:0]                      rd_data,
    output logic                                         rd_valid,
    output logic                                         err,
    output logic [BANKSPERGROUP-1:0]                     bank_open,
    output logic [BANKSPERGROUP-1:0][0:0]                rd_o_wr,
    output logic [BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0]   dqin,
    input  logic [BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0]   dqout,
    output logic [BANKSPERGROUP-1:0][ADDRWIDTH-1:0]      row,
    output logic [BANKSPERGROUP-1:0][COLWIDTH-1:0]       column
);

    localparam logic [1:0] c_op_act = 2'd0;
    localparam logic [1:0] c_op_rd  = 2'd1;
    localparam logic [1:0] c_op_wr  = 2'd2;
    localparam logic [1:0] c_op_pre = 2'd3;

    localparam int c_cntw = (BL > 1) ? $clog2(BL) : 1;
    localparam logic [c_cntw-1:0] c_last_beat = c_cntw'(BL - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WBURST = 2'd1,
        ST_RBURST = 2'd2
    } state_t;

    state_t                                       r_state;
    state_t                                       w_state_nxt;
    logic [c_cntw-1:0]                            r_cnt;
    logic [BAWIDTH-1:0]                           r_ba;
    logic                                         r_err;
    logic [BANKSPERGROUP-1:0]                     r_bank_open;
    logic [BANKSPERGROUP-1:0][ADDRWIDTH-1:0]      r_row;
    logic [BANKSPERGROUP-1:0][COLWIDTH-1:0]       r_col;
    logic                                         r_s1_valid;
    logic [BAWIDTH-1:0]                           r_s1_ba;
    logic                                         r_rd_valid;
    logic [DEVICE_WIDTH-1:0]                      r_rd_data;

    logic w_accept;
    logic w_tgt_open;
    logic w_illegal;
    logic w_last;

    assign cmd_ready  = (r_state == ST_IDLE) && !rst;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_tgt_open = r_bank_open[cmd_ba];
    assign w_illegal  = ((cmd_op == c_op_act) && w_tgt_open) ||
                        (((cmd_op == c_op_rd) || (cmd_op == c_op_wr)) && !w_tgt_open);
    assign w_last     = (r_cnt == c_last_beat);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_illegal) begin
                    if (cmd_op == c_op_rd)
                        w_state_nxt = ST_RBURST;
                    else if (cmd_op == c_op_wr)
                        w_state_nxt = ST_WBURST;
                end
            end
            ST_WBURST, ST_RBURST: begin
                if (w_last)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ba        <= '0;
            r_err       <= 1'b0;
            r_bank_open <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_ba     <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_err      <= w_accept && w_illegal;
            // Read pipeline drains on its own, independent of the FSM
            r_s1_valid <= (r_state == ST_RBURST);
            r_s1_ba    <= r_ba;
            r_rd_valid <= r_s1_valid;
            if (r_s1_valid)
                r_rd_data <= dqout[r_s1_ba];

            if (w_accept && !w_illegal) begin
                case (cmd_op)
                    c_op_act: begin
                        r_row[cmd_ba]       <= cmd_addr;
                        r_bank_open[cmd_ba] <= 1'b1;
                    end
                    c_op_pre: r_bank_open[cmd_ba] <= 1'b0;
                    default: begin
                        r_ba          <= cmd_ba;
                        r_col[cmd_ba] <= cmd_addr[COLWIDTH-1:0];
                        r_cnt         <= '0;
                    end
                endcase
            end

            // Column wraps inside the column space; the last beat's column is held
            if (r_state != ST_IDLE) begin
                r_cnt <= r_cnt + 1'b1;
                if (!w_last)
                    r_col[r_ba] <= r_col[r_ba] + 1'b1;
            end
        end
    end

    // Write strobe is suppressed during reset so an aborted beat never commits
    always_comb begin
        for (int b = 0; b < BANKSPERGROUP; b++) begin
            rd_o_wr[b] = 1'b0;
            dqin[b]    = '0;
        end
        if ((r_state == ST_WBURST) && !rst) begin
            rd_o_wr[r_ba] = 1'b1;
            dqin[r_ba]    = wr_data;
        end
    end

    assign wr_req    = (r_state == ST_WBURST) && !rst;
    assign err       = r_err;
    assign bank_open = r_bank_open;
    assign row       = r_row;
    assign column    = r_col;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_bank_group_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bank_group_sequencer
// Brief    : Bank-group memory model, directed scenarios and random traffic
//            checked against a transaction-level expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bank_group_sequencer;

    localparam int BAW = 2;
    localparam int NB  = 4;
    localparam int AW  = 17;
    localparam int CW  = 10;
    localparam int DW  = 4;
    localparam int BL  = 8;
    localparam logic [1:0] OP_ACT = 2'd0;
    localparam logic [1:0] OP_RD  = 2'd1;
    localparam logic [1:0] OP_WR  = 2'd2;
    localparam logic [1:0] OP_PRE = 2'd3;

    typedef struct {
        int            c;
        logic [DW-1:0] d;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   cmd_valid = 1'b0;
    logic [1:0]             cmd_op = '0;
    logic [BAW-1:0]         cmd_ba = '0;
    logic [AW-1:0]          cmd_addr = '0;
    logic [DW-1:0]          wr_data = '0;
    logic                   cmd_ready, wr_req, rd_valid, err;
    logic [DW-1:0]          rd_data;
    logic [NB-1:0]          bank_open;
    logic [NB-1:0][0:0]     rd_o_wr;
    logic [NB-1:0][DW-1:0]  dqin;
    logic [NB-1:0][DW-1:0]  dqout;
    logic [NB-1:0][AW-1:0]  row;
    logic [NB-1:0][CW-1:0]  column;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    bank_group_sequencer #(
        .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW), .DEVICE_WIDTH(DW), .BL(BL)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
        .wr_data(wr_data), .wr_req(wr_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .err(err),
        .bank_open(bank_open), .rd_o_wr(rd_o_wr), .dqin(dqin), .dqout(dqout),
        .row(row), .column(column)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Content of a never-written cell; address-dependent so misaddressing shows
    function automatic logic [DW-1:0] init_val(input int b, input int r2, input int col);
        int v;
        v = (b * 5 + r2 * 3 + col) ^ (col >> 4);
        return DW'(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- bank-group model (environment) ----------------
    logic [DW-1:0] bank_mem [NB][4][1<<CW];
    bit            bank_wr  [NB][4][1<<CW];

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            dqout[b] <= bank_wr[b][row[b][1:0]][column[b]] ?
                        bank_mem[b][row[b][1:0]][column[b]] :
                        init_val(b, int'(row[b][1:0]), int'(column[b]));
            if (rd_o_wr[b][0] === 1'b1) begin
                bank_mem[b][row[b][1:0]][column[b]] <= dqin[b];
                bank_wr[b][row[b][1:0]][column[b]]  <= 1'b1;
            end
        end
    end

    // ---------------- read-stream monitor ----------------
    beat_t mon_q[$];
    initial begin : monitor
        beat_t m;
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                m.c = cyc;
                m.d = rd_data;
                mon_q.push_back(m);
            end
        end
    end

    // ---------------- transaction-level expectation model ----------------
    logic [NB-1:0]  m_open;
    logic [AW-1:0]  m_row [NB];
    logic [CW-1:0]  m_col [NB];
    logic [DW-1:0]  ref_mem [NB][4][1<<CW];
    bit             ref_wr  [NB][4][1<<CW];
    beat_t          exp_rd[$];

    initial begin : scoreboard
        int            c, busy_until, err_at, b_t, b_kind, b_ba;
        logic [CW-1:0] b_start, col;
        bit            wact, ract, rd_zero;
        beat_t         e;
        busy_until = 0; err_at = -1; b_t = 0; b_kind = 0; b_ba = 0;
        b_start = '0; rd_zero = 1'b1; m_open = '0;
        for (int b = 0; b < NB; b++) begin
            m_row[b] = '0;
            m_col[b] = '0;
        end
        forever begin
            @(negedge clk);
            c = cyc;
            if (rst) begin
                chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
                chk("rst_rd_o_wr", 64'(rd_o_wr), 64'd0);
                m_open = '0;
                for (int b = 0; b < NB; b++) begin
                    m_row[b] = '0;
                    m_col[b] = '0;
                end
                busy_until = 0; err_at = -1; b_kind = 0; rd_zero = 1'b1;
                exp_rd.delete();
            end else begin
                wact = (b_kind == 1) && (c > b_t) && (c <= b_t + BL);
                ract = (b_kind == 2) && (c > b_t) && (c <= b_t + BL);
                if (wact || ract)
                    m_col[b_ba] = b_start + CW'(c - b_t - 1);
                chk("cmd_ready", 64'(cmd_ready), 64'(c >= busy_until));
                chk("wr_req", 64'(wr_req), 64'(wact));
                chk("err", 64'(err), 64'(c == err_at));
                chk("bank_open", 64'(bank_open), 64'(m_open));
                for (int b = 0; b < NB; b++) begin
                    chk($sformatf("row[%0d]", b), 64'(row[b]), 64'(m_row[b]));
                    chk($sformatf("column[%0d]", b), 64'(column[b]), 64'(m_col[b]));
                    chk($sformatf("rd_o_wr[%0d]", b), 64'(rd_o_wr[b]), 64'(wact && b == b_ba));
                    chk($sformatf("dqin[%0d]", b), 64'(dqin[b]),
                        (wact && b == b_ba) ? 64'(wr_data) : 64'd0);
                end
                if (wact) begin
                    ref_mem[b_ba][m_row[b_ba][1:0]][m_col[b_ba]] = wr_data;
                    ref_wr[b_ba][m_row[b_ba][1:0]][m_col[b_ba]]  = 1'b1;
                end
                if (exp_rd.size() > 0 && exp_rd[0].c == c) begin
                    e = exp_rd.pop_front();
                    chk("rd_valid", 64'(rd_valid), 64'd1);
                    chk("rd_data", 64'(rd_data), 64'(e.d));
                    rd_zero = 1'b0;
                end else begin
                    chk("rd_valid", 64'(rd_valid), 64'd0);
                    if (rd_zero)
                        chk("rd_data_reset", 64'(rd_data), 64'd0);
                end
                if (cmd_valid && c >= busy_until) begin
                    case (cmd_op)
                        OP_ACT: begin
                            if (m_open[cmd_ba]) err_at = c + 1;
                            else begin
                                m_open[cmd_ba] = 1'b1;
                                m_row[cmd_ba]  = cmd_addr;
                            end
                        end
                        OP_PRE: m_open[cmd_ba] = 1'b0;
                        default: begin
                            if (!m_open[cmd_ba]) err_at = c + 1;
                            else begin
                                b_kind     = (cmd_op == OP_WR) ? 1 : 2;
                                b_t        = c;
                                b_ba       = int'(cmd_ba);
                                b_start    = cmd_addr[CW-1:0];
                                busy_until = c + BL + 1;
                                if (cmd_op == OP_RD) begin
                                    for (int i = 0; i < BL; i++) begin
                                        col = b_start + CW'(i);
                                        e.c = c + 3 + i;
                                        e.d = ref_wr[b_ba][m_row[b_ba][1:0]][col] ?
                                              ref_mem[b_ba][m_row[b_ba][1:0]][col] :
                                              init_val(b_ba, int'(m_row[b_ba][1:0]), int'(col));
                                        exp_rd.push_back(e);
                                    end
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [1:0] op, input int ba, input logic [AW-1:0] addr, output int t);
        int  n;
        bit  done;
        n = 0; done = 1'b0; t = -1;
        cmd_valid = 1'b1; cmd_op = op; cmd_ba = BAW'(ba); cmd_addr = addr;
        while (!done) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                t = cyc;
                done = 1'b1;
            end else if (++n > 40) begin
                n_chk++; n_err++;
                $display("FAIL send_timeout: cmd_ready never 1 within 40 cycles (op %0d)", op);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int            t, t1, t2, opr;
        logic [CW-1:0] colexp [8];
        logic [AW-1:0] rows [4];
        colexp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005};
        rows   = '{17'h00000, 17'h1ABCD, 17'h12342, 17'h00777};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("init_bank_open", 64'(bank_open), 64'd0);
        chk("init_column", 64'(column), 64'd0);
        chk("init_rd_data", 64'(rd_data), 64'd0);
        @(posedge clk); #1;

        // ACT b2
        send(OP_ACT, 2, 17'h1ABCD, t);
        @(negedge clk);
        chk("act_bank_open", 64'(bank_open), 64'b0100);
        chk("act_row2", 64'(row[2]), 64'h1ABCD);
        chk("act_err", 64'(err), 64'd0);
        @(posedge clk); #1;

        // WR b2 wrapping at the top of the column space
        send(OP_WR, 2, 17'h003FE, t);
        for (int i = 0; i < BL; i++) begin
            wr_data = DW'(i + 1);
            @(negedge clk);
            chk($sformatf("wr_col_beat%0d", i), 64'(column[2]), 64'(colexp[i]));
            chk($sformatf("wr_rd_o_wr_beat%0d", i), 64'(rd_o_wr), 64'b0100);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("wr_ready_after", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;

        // Back-to-back reads of the written burst
        mon_q.delete();
        send(OP_RD, 2, 17'h003FE, t1);
        send(OP_RD, 2, 17'h003FE, t2);
        chk("rd2_accept_cycle", 64'(t2 - t1), 64'd9);
        repeat (12) @(posedge clk);
        #1;
        chk("rd_beats", 64'(mon_q.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < mon_q.size()) begin
                chk($sformatf("rd_beat%0d_cycle", i), 64'(mon_q[i].c - (i < 8 ? t1 : t2)),
                    64'(3 + (i % 8)));
                chk($sformatf("rd_beat%0d_data", i), 64'(mon_q[i].d), 64'((i % 8) + 1));
            end
        end

        // Illegal commands and PRE behaviour
        send(OP_RD, 1, 17'h00000, t);
        @(negedge clk);
        chk("rd_closed_err", 64'(err), 64'd1);
        chk("rd_closed_open", 64'(bank_open), 64'b0100);
        @(posedge clk); #1;
        @(negedge clk);
        chk("err_one_cycle", 64'(err), 64'd0);
        @(posedge clk); #1;
        send(OP_ACT, 2, 17'h00005, t);
        @(negedge clk);
        chk("act_open_err", 64'(err), 64'd1);
        chk("act_open_row", 64'(row[2]), 64'h1ABCD);
        @(posedge clk); #1;
        send(OP_PRE, 2, 17'h00000, t);
        @(negedge clk);
        chk("pre_bank_open", 64'(bank_open), 64'd0);
        chk("pre_row_hold", 64'(row[2]), 64'h1ABCD);
        @(posedge clk); #1;
        send(OP_RD, 2, 17'h003FE, t);
        @(negedge clk);
        chk("rd_after_pre_err", 64'(err), 64'd1);
        @(posedge clk); #1;
        send(OP_PRE, 0, 17'h00000, t);
        @(negedge clk);
        chk("pre_closed_no_err", 64'(err), 64'd0);
        @(posedge clk); #1;

        // Reset during write beat 4
        send(OP_ACT, 1, 17'h00777, t);
        send(OP_WR, 1, 17'h00010, t);
        for (int i = 0; i < 3; i++) begin
            wr_data = DW'(9 + i);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        wr_data = 4'd12;
        @(negedge clk);
        chk("rst_beat_rd_o_wr", 64'(rd_o_wr), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_open", 64'(bank_open), 64'd0);
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);
        chk("post_rst_wr_req", 64'(wr_req), 64'd0);
        chk("post_rst_col1", 64'(column[1]), 64'd0);
        chk("post_rst_row1", 64'(row[1]), 64'd0);
        @(posedge clk); #1;
        send(OP_ACT, 1, 17'h00777, t);
        mon_q.delete();
        send(OP_RD, 1, 17'h00010, t);
        repeat (12) @(posedge clk);
        #1;
        chk("rst_rd_beats", 64'(mon_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < mon_q.size())
                chk($sformatf("rst_rd_beat%0d", i), 64'(mon_q[i].d),
                    (i < 3) ? 64'(9 + i) : 64'(init_val(1, 3, 16 + i)));
        end

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 299) == 0);
            cmd_valid = ($urandom_range(0, 9) < 7);
            opr       = int'($urandom_range(0, 99));
            cmd_op    = (opr < 30) ? OP_ACT : (opr < 50) ? OP_PRE : (opr < 75) ? OP_RD : OP_WR;
            cmd_ba    = BAW'($urandom_range(0, NB - 1));
            if (cmd_op == OP_ACT)
                cmd_addr = rows[$urandom_range(0, 3)];
            else begin
                cmd_addr = AW'($urandom);
                cmd_addr[CW-1:0] = $urandom_range(0, 1) ? CW'(1020 + $urandom_range(0, 3))
                                                          : CW'($urandom_range(0, 15));
            end
            wr_data = DW'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
